// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared store-op encodings, byte-enable constants and the
// buffered entry layout used by store_buffer and store_lane_pack.
package store_buffer_pkg;

    localparam logic [1:0] ST_SW  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SB  = 2'b10;
    localparam logic [1:0] ST_RSV = 2'b11;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // One buffered store: word address (bits [31:2]), lane data, byte enables.
    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_lane_pack.sv
// store_lane_pack: combinational store narrowing. Replicates the store value
// across byte lanes and selects byte enables from the op and low address bits.
// Ports:
//   op      in  2   store width (ST_SW / ST_SH / ST_SB / ST_RSV)
//   addr_lo in  2   byte address bits [1:0]
//   data    in  32  register data, value in low bits
//   be      out 4   byte enables (0 for the reserved op)
//   wdata   out 32  lane-replicated write data
module store_lane_pack
    import store_buffer_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    always_comb begin
        be    = '0;
        wdata = '0;
        case (op)
            ST_SW: begin
                be    = BE_WORD;
                wdata = data;
            end
            ST_SH: begin
                be    = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata = {2{data[15:0]}};
            end
            ST_SB: begin
                be    = BE_BYTE0 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry in-order store FIFO between the MEM stage and data
// memory. Accepted stores are narrowed by store_lane_pack and presented from
// the head entry one cycle later; the head pops on mem_req && mem_ack.
// Optional feature macro: STORE_ALIGN_CHECK_EN -- when defined, misaligned sw/sh
// are dropped and flagged with a one-cycle align_err pulse; otherwise align_err
// is tied low and the offending low address bits are ignored.
// Ports:
//   clk, reset (async, active-low)
//   st_valid/st_ready, st_op, st_addr, st_data   store request
//   mem_req/mem_ack, mem_addr, mem_wdata, mem_be head entry to memory
//   count                                        occupied entries
//   align_err                                    misaligned-store pulse
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [1:0]               st_op,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     align_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    sb_entry_t     fifo_mem [DEPTH];

    logic [3:0]  pack_be;
    logic [31:0] pack_wdata;
    logic        accept, misaligned, push, pop;

    store_lane_pack u_lane_pack (
        .op      (st_op),
        .addr_lo (st_addr[1:0]),
        .data    (st_data),
        .be      (pack_be),
        .wdata   (pack_wdata)
    );

    assign st_ready = (count_q != FULL_CNT);
    assign accept   = st_valid && st_ready;

`ifdef STORE_ALIGN_CHECK_EN
    assign misaligned = ((st_op == ST_SW) && (st_addr[1:0] != 2'b00)) ||
                        ((st_op == ST_SH) && st_addr[0]);

    logic align_err_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= accept && misaligned;
        end
    end
    assign align_err = align_err_q;
`else
    assign misaligned = 1'b0;
    assign align_err  = 1'b0;
`endif

    // Reserved op is handshaken but never enqueued.
    assign push = accept && (st_op != ST_RSV) && !misaligned;
    assign pop  = mem_req && mem_ack;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage needs no reset: it is only observed through a nonzero count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{word_addr: st_addr[31:2], wdata: pack_wdata, be: pack_be};
        end
    end

    assign count   = count_q;
    assign mem_req = (count_q != '0);

    // Outputs forced to zero when empty so reset clears them immediately.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (mem_req) begin
            mem_addr  = {fifo_mem[rd_ptr_q].word_addr, 2'b00};
            mem_wdata = fifo_mem[rd_ptr_q].wdata;
            mem_be    = fifo_mem[rd_ptr_q].be;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized checks of store_buffer against a
// queue-based reference model of the store semantics.
module tb_store_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [1:0]  st_op = 2'b00;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [$clog2(DEPTH):0] count;
    logic        align_err;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_op     (st_op),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .count     (count),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    logic exp_align = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef STORE_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model's view of the current state.
    task automatic check_all();
        chk("st_ready", 32'(st_ready), 32'(q.size() != DEPTH));
        chk("count", 32'(count), 32'(q.size()));
        chk("mem_req", 32'(mem_req), 32'(q.size() != 0));
        chk("align_err", 32'(align_err), 32'(exp_align));
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].addr);
            chk("mem_wdata", mem_wdata, q[0].data);
            chk("mem_be", 32'(mem_be), 32'(q[0].be));
        end else begin
            chk("mem_addr_idle", mem_addr, 32'h0);
            chk("mem_be_idle", 32'(mem_be), 32'h0);
        end
    endtask

    // One clock of stimulus: apply inputs, check before the edge, advance model.
    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic ack);
        ent_t e;
        logic acc, bad;
        st_valid = v;
        st_op    = op;
        st_addr  = a;
        st_data  = d;
        mem_ack  = ack;
        @(negedge clk);
        check_all();
        acc = v && (q.size() != DEPTH);
        bad = ALIGN_EN && (((op == 2'd0) && (a % 4 != 0)) || ((op == 2'd1) && (a % 2 != 0)));
        if ((q.size() != 0) && ack) void'(q.pop_front());
        exp_align = acc && bad;
        if (acc && !bad && op != 2'd3) begin
            e.addr = a - (a % 4);
            case (op)
                2'd0: begin e.be = 4'hF; e.data = d; end
                2'd1: begin
                    e.be   = ((a / 2) % 2 == 1) ? 4'hC : 4'h3;
                    e.data = (d % 32'h10000) * 32'h10001;
                end
                default: begin
                    e.be   = 4'(1 << (a % 4));
                    e.data = (d % 32'h100) * 32'h01010101;
                end
            endcase
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 2'd0, 32'h0, 32'h0, ack);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        chk("drain_empty", 32'(count), 32'h0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_st_ready", 32'(st_ready), 32'h1);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_align_err", 32'(align_err), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // sb into empty buffer, visible after the accepting edge
        step(1'b1, 2'd2, 32'h0000_1003, 32'h0000_00AB, 1'b0);
        chk("sb_req", 32'(mem_req), 32'h1);
        chk("sb_addr", mem_addr, 32'h0000_1000);
        chk("sb_be", 32'(mem_be), 32'h8);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        drain();

        // sh upper half
        step(1'b1, 2'd1, 32'h0000_2002, 32'h0000_1234, 1'b0);
        chk("sh_addr", mem_addr, 32'h0000_2000);
        chk("sh_be", 32'(mem_be), 32'hC);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        drain();

        // Fill with three sw, third refused; then pop in order
        step(1'b1, 2'd0, 32'h0000_0100, 32'h1111_1111, 1'b0);
        step(1'b1, 2'd0, 32'h0000_0104, 32'h2222_2222, 1'b0);
        step(1'b1, 2'd0, 32'h0000_0108, 32'h3333_3333, 1'b0);
        chk("full_ready", 32'(st_ready), 32'h0);
        chk("full_count", 32'(count), 32'h2);
        chk("full_head", mem_wdata, 32'h1111_1111);
        idle(1'b1);
        chk("pop1_head", mem_wdata, 32'h2222_2222);
        idle(1'b1);
        chk("pop2_ready", 32'(st_ready), 32'h1);
        chk("pop2_count", 32'(count), 32'h0);

        // Full buffer: push and ack together -> push refused, count 2->1
        step(1'b1, 2'd0, 32'h0000_0200, 32'hAAAA_0001, 1'b0);
        step(1'b1, 2'd0, 32'h0000_0204, 32'hAAAA_0002, 1'b0);
        step(1'b1, 2'd0, 32'h0000_0208, 32'hAAAA_0003, 1'b1);
        chk("fullpop_count", 32'(count), 32'h1);
        chk("fullpop_head", mem_wdata, 32'hAAAA_0002);
        drain();

        // Reserved op accepted but discarded
        step(1'b1, 2'd3, 32'h0000_0300, 32'hDEAD_BEEF, 1'b0);
        chk("rsv_req", 32'(mem_req), 32'h0);

        // Misaligned sw
        step(1'b1, 2'd0, 32'h0000_3001, 32'h5555_AAAA, 1'b0);
        if (ALIGN_EN) begin
            chk("mis_align_err", 32'(align_err), 32'h1);
            chk("mis_req", 32'(mem_req), 32'h0);
            idle(1'b0);
            chk("mis_pulse_end", 32'(align_err), 32'h0);
        end else begin
            chk("mis_addr", mem_addr, 32'h0000_3000);
            chk("mis_be", 32'(mem_be), 32'hF);
            chk("mis_align_err", 32'(align_err), 32'h0);
        end
        drain();

        // Reset mid-operation with mem_ack asserted
        step(1'b1, 2'd0, 32'h0000_4000, 32'h0BAD_0001, 1'b0);
        step(1'b1, 2'd2, 32'h0000_4005, 32'h0BAD_0002, 1'b0);
        chk("prerst_count", 32'(count), 32'h2);
        mem_ack  = 1'b1;
        st_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_req", 32'(mem_req), 32'h0);
        chk("midrst_count", 32'(count), 32'h0);
        chk("midrst_ready", 32'(st_ready), 32'h1);
        chk("midrst_be", 32'(mem_be), 32'h0);
        q.delete();
        exp_align = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_ack = 1'b0;
        chk("postrst_ready", 32'(st_ready), 32'h1);
        chk("postrst_count", 32'(count), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 2'($urandom % 4), $urandom, $urandom,
                 ($urandom % 2) == 1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=stalled expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning FIFO entry count (power of two, ≥2).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port st_valid  input  1  store request valid from MEM stage.
REQ-005 SHALL have port st_ready  output  1  buffer can accept a request this cycle.
REQ-006 SHALL have port st_op  input  2  store width (00 sw, 01 sh, 10 sb, 11 reserved).
REQ-007 SHALL have port st_addr  input  32  byte address.
REQ-008 SHALL have port st_data  input  32  register data, value in low bits.
REQ-009 SHALL have port mem_req  output  1  head entry presented to data memory.
REQ-010 SHALL have port mem_ack  input  1  memory accepted the presented entry.
REQ-011 SHALL have port mem_addr  output  32  word address, bits [1:0] always 0.
REQ-012 SHALL have port mem_wdata  output  32  lane-replicated write data.
REQ-013 SHALL have port mem_be  output  4  byte enables, bit i = byte lane i.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-015 SHALL have port align_err  output  1  one-cycle misaligned-store pulse.

Function
REQ-016 SHALL accept a request on a rising clk edge when st_valid && st_ready; st_ready SHALL equal (count != DEPTH).
REQ-017 SHALL narrow sw to be=1111, wdata=st_data.
REQ-018 SHALL narrow sh to be=(addr[1]?1100:0011), wdata={2{st_data[15:0]}}.
REQ-019 SHALL narrow sb to be=(0001<<addr[1:0]), wdata={4{st_data[7:0]}}.
REQ-020 SHALL accept op 11 (st_ready honoured) and discard it without enqueueing.
REQ-021 SHALL drive mem_req = (count != 0); mem_addr/wdata/be SHALL come from the head entry and stay stable while mem_req && !mem_ack.
REQ-022 SHALL pop the head on mem_req && mem_ack; back-to-back pops on consecutive cycles are allowed.
REQ-023 SHALL have latency 1: an entry accepted into an empty buffer at edge N raises mem_req after edge N; no combinational bypass.
REQ-024 SHALL, on simultaneous push and pop, keep count unchanged; when full, st_ready=0, so no push occurs even if a pop is in progress.
REQ-025 SHALL wrap read/write pointers modulo DEPTH, preserving FIFO order.

Reset
REQ-026 SHALL, on reset low, immediately clear count, pointers, mem_req=0, mem_be=0, mem_addr=0, mem_wdata=0, align_err=0, st_ready=1.
REQ-027 SHALL discard all buffered entries on a reset mid-operation; a mem_ack during reset SHALL have no effect.

Configuration
REQ-028 SHALL use macro STORE_ALIGN_CHECK_EN.
REQ-029 With the macro defined, the block SHALL flag an accepted sw with addr[1:0]!=0, or an accepted sh with addr[0]!=0, by pulsing align_err for the cycle after acceptance and SHALL NOT enqueue the request.
REQ-030 Without the macro, align_err SHALL be tied 0, sw SHALL ignore addr[1:0], and sh SHALL ignore addr[0].

Structure
REQ-031 SHALL take op encodings (ST_SW, ST_SH, ST_SB) and byte-enable constants from a shared package.
REQ-032 SHALL place narrowing (REQ-017..019) in a combinational sub-module store_lane_pack; FIFO and control SHALL live in store_buffer.

Verification
REQ-033 sb addr=0x1003, data=0x000000AB, empty buffer -> next cycle mem_req=1, mem_addr=0x1000, be=1000, wdata=0xABABABAB.
REQ-034 sh addr=0x2002, data=0x1234 -> be=1100, wdata=0x12341234, mem_addr=0x2000.
REQ-035 Three sw, mem_ack held 0, DEPTH=2 -> st_ready=0 after two accepts, count=2; ack two cycles -> entries pop in order, st_ready returns 1.
REQ-036 Full buffer with push and ack in the same cycle -> push refused, count 2->1.
REQ-037 STORE_ALIGN_CHECK_EN defined, sw addr=0x3001 -> align_err=1 for one cycle, mem_req stays 0; undefined -> mem_addr=0x3000, be=1111.
REQ-038 reset low while count=2 and mem_req=1 -> mem_req=0 and count=0 immediately; after release st_ready=1.
